// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port VDP VRAM between the CPU data port and
// the render pipeline. The renderer has fixed priority. The CPU holds a one-deep
// request buffer, and a streak counter bounds how long a buffered CPU access
// can be starved.
module vram_arbiter #(
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    // CPU data port
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_di,
    output logic              cpu_busy,
    output logic [DATA_W-1:0] cpu_do,
    output logic              cpu_do_valid,
    // Render pipeline
    input  logic              ren_req,
    input  logic [ADDR_W-1:0] ren_addr,
    output logic              ren_ack,
    output logic [DATA_W-1:0] ren_do,
    output logic              ren_valid,
    // VRAM
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_di,
    input  logic [DATA_W-1:0] vram_do
);

    localparam int unsigned         STREAK_W   = $clog2(MAX_WAIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_WAIT);

    typedef enum logic [0:0] {StIdle, StPend} state_e;

    state_e              state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                buf_load;
    logic                buf_we_q;
    logic [ADDR_W-1:0]   buf_addr_q;
    logic [DATA_W-1:0]   buf_di_q;
    logic                cpu_gnt;
    logic                cpu_rd_q;
    logic                ren_rd_q;
    logic [DATA_W-1:0]   cpu_do_q;

    // Grant decision: the renderer wins unless it is idle or has hit the streak bound
    always_comb begin
        cpu_gnt = (state_q == StPend) && (!ren_req || (streak_q == STREAK_MAX));
        ren_ack = ren_req && !cpu_gnt;
    end

    // Next-state logic for the request buffer FSM and the renderer streak counter
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        buf_load = 1'b0;
        case (state_q)
            StIdle: begin
                streak_d = '0;
                if (cpu_req) begin
                    buf_load = 1'b1;
                    state_d  = StPend;
                end
            end
            StPend: begin
                if (cpu_gnt) begin
                    state_d  = StIdle;
                    streak_d = '0;
                end else if (ren_ack && (streak_q != STREAK_MAX)) begin
                    streak_d = streak_q + STREAK_W'(1);
                end
            end
            default: begin
                state_d  = StIdle;
                streak_d = '0;
            end
        endcase
    end

    // State, buffer and read-return registers; reset drops any buffered or in-flight access
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            streak_q   <= '0;
            buf_we_q   <= 1'b0;
            buf_addr_q <= '0;
            buf_di_q   <= '0;
            cpu_rd_q   <= 1'b0;
            ren_rd_q   <= 1'b0;
            cpu_do_q   <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            if (buf_load) begin
                buf_we_q   <= cpu_we;
                buf_addr_q <= cpu_addr;
                buf_di_q   <= cpu_di;
            end
            cpu_rd_q <= cpu_gnt && !buf_we_q;
            ren_rd_q <= ren_ack;
            // Capture the returning CPU read so cpu_do holds it until the next one
            if (cpu_rd_q) begin
                cpu_do_q <= vram_do;
            end
        end
    end

    // VRAM drive for the current grant; bus parks at zero when nobody is granted
    always_comb begin
        vram_we   = 1'b0;
        vram_addr = '0;
        vram_di   = '0;
        if (cpu_gnt) begin
            vram_we   = buf_we_q;
            vram_addr = buf_addr_q;
            vram_di   = buf_di_q;
        end else if (ren_ack) begin
            vram_addr = ren_addr;
        end
    end

    // Port outputs; cpu_do forwards VRAM data in the return cycle, then holds the latch
    always_comb begin
        cpu_busy     = (state_q == StPend);
        cpu_do_valid = cpu_rd_q;
        cpu_do       = cpu_rd_q ? vram_do : cpu_do_q;
        ren_do       = vram_do;
        ren_valid    = ren_rd_q;
    end

    // Only one requester may own the VRAM in a given cycle
    a_one_owner: assert property (@(posedge clk) disable iff (rst) !(cpu_gnt && ren_ack));

    // The starvation counter never passes its bound
    a_streak_bound: assert property (@(posedge clk) disable iff (rst) streak_q <= STREAK_MAX);

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 1-cycle-latency VRAM model.
module tb_vram_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [13:0] cpu_addr;
    logic [7:0]  cpu_di;
    logic        cpu_busy;
    logic [7:0]  cpu_do;
    logic        cpu_do_valid;
    logic        ren_req;
    logic [13:0] ren_addr;
    logic        ren_ack;
    logic [7:0]  ren_do;
    logic        ren_valid;
    logic        vram_we;
    logic [13:0] vram_addr;
    logic [7:0]  vram_di;
    logic [7:0]  vram_do;

    int n_total = 0;
    int n_bad   = 0;

    vram_arbiter #(
        .ADDR_W   (14),
        .DATA_W   (8),
        .MAX_WAIT (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_di       (cpu_di),
        .cpu_busy     (cpu_busy),
        .cpu_do       (cpu_do),
        .cpu_do_valid (cpu_do_valid),
        .ren_req      (ren_req),
        .ren_addr     (ren_addr),
        .ren_ack      (ren_ack),
        .ren_do       (ren_do),
        .ren_valid    (ren_valid),
        .vram_we      (vram_we),
        .vram_addr    (vram_addr),
        .vram_di      (vram_di),
        .vram_do      (vram_do)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // VRAM model: addresses 0..7 preloaded with 0x5A^addr, everything else 0
    bit [7:0] mem [0:16383];
    bit       wr  [0:16383];

    function automatic logic [7:0] preload(input int a);
        return (a < 8) ? (8'h5A ^ 8'(a)) : 8'h00;
    endfunction

    function automatic logic [7:0] mem_rd(input int a);
        return wr[a] ? mem[a] : preload(a);
    endfunction

    always @(posedge clk) begin
        if (vram_we) begin
            mem[vram_addr] <= vram_di;
            wr[vram_addr]  <= 1'b1;
        end
        vram_do <= mem_rd(int'(vram_addr));
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        cpu_req  = 1'b0;
        cpu_we   = 1'b0;
        cpu_addr = '0;
        cpu_di   = '0;
        ren_req  = 1'b0;
        ren_addr = '0;
        repeat (2) tick();

        // Power-on reset state
        rst = 1'b0;
        #1;
        check_eq("rst busy", 32'(cpu_busy), 0);
        check_eq("rst cpu_do_valid", 32'(cpu_do_valid), 0);
        check_eq("rst ren_valid", 32'(ren_valid), 0);
        check_eq("rst vram_we", 32'(vram_we), 0);
        check_eq("rst ren_ack", 32'(ren_ack), 0);
        check_eq("rst cpu_do", 32'(cpu_do), 0);
        check_eq("rst vram_addr", 32'(vram_addr), 0);

        // Test 1: reset while a CPU write is pending behind a busy renderer
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0100; cpu_di = 8'h77;
        ren_req = 1'b1; ren_addr = 14'h0004;
        #1;
        check_eq("t1 tie ren_ack", 32'(ren_ack), 1);
        tick();
        cpu_req = 1'b0;
        #1;
        check_eq("t1 pend busy", 32'(cpu_busy), 1);
        check_eq("t1 pend ren_ack", 32'(ren_ack), 1);
        tick();
        rst = 1'b1;
        tick();
        ren_req = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check_eq("t1 busy", 32'(cpu_busy), 0);
        check_eq("t1 cpu_do_valid", 32'(cpu_do_valid), 0);
        check_eq("t1 ren_valid", 32'(ren_valid), 0);
        check_eq("t1 vram_we", 32'(vram_we), 0);
        check_eq("t1 vram_addr", 32'(vram_addr), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            check_eq("t1 quiet we", 32'(vram_we), 0);
            check_eq("t1 quiet valid", 32'(cpu_do_valid), 0);
        end
        check_eq("t1 dropped write", 32'(mem_rd(14'h0100)), 0);

        // Test 2: CPU write with renderer idle
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h3F00; cpu_di = 8'hA5;
        #1;
        check_eq("t2 T busy", 32'(cpu_busy), 0);
        check_eq("t2 T we", 32'(vram_we), 0);
        tick();
        cpu_req = 1'b0;
        #1;
        check_eq("t2 T+1 we", 32'(vram_we), 1);
        check_eq("t2 T+1 addr", 32'(vram_addr), 32'h3F00);
        check_eq("t2 T+1 di", 32'(vram_di), 32'hA5);
        check_eq("t2 T+1 busy", 32'(cpu_busy), 1);
        tick();
        #1;
        check_eq("t2 T+2 busy", 32'(cpu_busy), 0);
        check_eq("t2 T+2 we", 32'(vram_we), 0);
        check_eq("t2 T+2 addr", 32'(vram_addr), 0);

        // Test 3: CPU read back of the same location
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h3F00;
        #1;
        tick();
        cpu_req = 1'b0;
        #1;
        check_eq("t3 T+1 we", 32'(vram_we), 0);
        check_eq("t3 T+1 addr", 32'(vram_addr), 32'h3F00);
        check_eq("t3 T+1 valid", 32'(cpu_do_valid), 0);
        tick();
        #1;
        check_eq("t3 T+2 valid", 32'(cpu_do_valid), 1);
        check_eq("t3 T+2 data", 32'(cpu_do), 32'hA5);
        tick();
        #1;
        check_eq("t3 T+3 valid", 32'(cpu_do_valid), 0);
        repeat (2) tick();
        #1;
        check_eq("t3 T+5 hold", 32'(cpu_do), 32'hA5);

        // Test 4: starvation bound with renderer requesting every cycle
        tick();
        ren_req = 1'b1; ren_addr = 14'h0002;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0005;
        #1;
        check_eq("t4 T ren_ack", 32'(ren_ack), 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            cpu_req = 1'b0;
            #1;
            check_eq("t4 streak ren_ack", 32'(ren_ack), 1);
            check_eq("t4 streak addr", 32'(vram_addr), 32'h0002);
            check_eq("t4 streak busy", 32'(cpu_busy), 1);
        end
        tick();
        #1;
        check_eq("t4 T+5 ren_ack", 32'(ren_ack), 0);
        check_eq("t4 T+5 addr", 32'(vram_addr), 32'h0005);
        check_eq("t4 T+5 we", 32'(vram_we), 0);
        tick();
        #1;
        check_eq("t4 T+6 ren_ack", 32'(ren_ack), 1);
        check_eq("t4 T+6 cpu valid", 32'(cpu_do_valid), 1);
        check_eq("t4 T+6 cpu data", 32'(cpu_do), 32'h5F);
        check_eq("t4 T+6 ren_valid", 32'(ren_valid), 0);
        tick();
        ren_req = 1'b0;
        #1;
        check_eq("t4 T+7 ren_valid", 32'(ren_valid), 1);
        check_eq("t4 T+7 ren_do", 32'(ren_do), 32'h58);

        // Test 5: cpu_req held high, renderer requesting in the idle slots
        for (int k = 0; k < 6; k++) begin
            tick();
            cpu_req  = 1'b1;
            cpu_we   = 1'b1;
            cpu_addr = 14'(16'h1000 + k);
            cpu_di   = 8'(8'h10 + k);
            ren_req  = ((k % 2) == 0);
            ren_addr = 14'h0003;
            #1;
            check_eq("t5 busy", 32'(cpu_busy), 32'(k % 2));
            check_eq("t5 we", 32'(vram_we), 32'(k % 2));
            check_eq("t5 ren_valid", 32'(ren_valid), 32'(k % 2));
            if ((k % 2) == 1) begin
                check_eq("t5 cpu addr", 32'(vram_addr), 32'h1000 + 32'(k - 1));
                check_eq("t5 cpu di", 32'(vram_di), 32'h10 + 32'(k - 1));
                check_eq("t5 ren_do", 32'(ren_do), 32'h59);
            end else begin
                check_eq("t5 ren_ack", 32'(ren_ack), 1);
                check_eq("t5 ren addr", 32'(vram_addr), 32'h0003);
            end
        end
        tick();
        cpu_req = 1'b0;
        ren_req = 1'b0;
        #1;
        check_eq("t5 end busy", 32'(cpu_busy), 0);
        check_eq("t5 end we", 32'(vram_we), 0);
        check_eq("t5 mem 1000", 32'(mem_rd(14'h1000)), 32'h10);
        check_eq("t5 mem 1002", 32'(mem_rd(14'h1002)), 32'h12);
        check_eq("t5 mem 1004", 32'(mem_rd(14'h1004)), 32'h14);
        check_eq("t5 mem 1001", 32'(mem_rd(14'h1001)), 32'h00);

        // Test 6: renderer stream over the preloaded addresses
        for (int k = 0; k < 8; k++) begin
            tick();
            ren_req  = 1'b1;
            ren_addr = 14'(k);
            #1;
            check_eq("t6 ren_ack", 32'(ren_ack), 1);
            if (k > 0) begin
                check_eq("t6 ren_valid", 32'(ren_valid), 1);
                check_eq("t6 ren_do", 32'(ren_do), 32'(8'h5A ^ 8'(k - 1)));
            end
        end
        tick();
        ren_req = 1'b0;
        #1;
        check_eq("t6 last valid", 32'(ren_valid), 1);
        check_eq("t6 last data", 32'(ren_do), 32'h5D);
        tick();
        #1;
        check_eq("t6 after valid", 32'(ren_valid), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
